// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types for the L1-to-L2 port arbiter
// Purpose: FSM state and requester-side enumerations used by cache_arbiter
//          and its round-robin picker.
// Ports:   none (package).
package cache_arb_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    SIDE_I,
    SIDE_D
  } arb_side_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// rtl/cache_arbiter_rr_pick.sv - combinational two-way round-robin choice
// Purpose: picks which L1 side gets the L2 port when the arbiter is idle.
// Ports:
//   i_req      in   I-side request pending
//   d_req      in   D-side request pending (read or write-back)
//   last_grant in   side granted most recently
//   grant      out  chosen side (meaningful only when valid=1)
//   valid      out  at least one side is requesting
module arb_rr_pick
  import cache_arb_types::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_side_t last_grant,
  output arb_side_t grant,
  output logic      valid
);

  always_comb begin
    valid = i_req | d_req;
    grant = SIDE_I;
    if (i_req && d_req) begin
      // Contended: the side that did not go last wins.
      grant = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
    end else if (d_req) begin
      grant = SIDE_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one L2 port between the L1 I and D miss paths
// Purpose: grants one L1 side per transaction in round-robin order, forwards
//          the L2 command of the granted side, returns the L2 completion to
//          that side only, and counts cycles a request waits on the other grant.
// Ports:
//   clk, reset                          clock; asynchronous active-high reset
//   i_read, i_address                   I-side line read request
//   i_rdata, i_resp                     I-side read line and completion pulse
//   d_read, d_write, d_address, d_wdata D-side read / write-back request
//   d_rdata, d_resp                     D-side read line and completion pulse
//   l2_read, l2_write, l2_address,
//   l2_wdata                            command to L2
//   l2_rdata, l2_resp                   L2 read line and completion pulse
//   contention_cnt                      saturating blocked-request cycle count
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [CNT_WIDTH-1:0]  contention_cnt
);

  arb_state_t           state_q, state_d;
  arb_side_t            last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic      d_req;
  logic      pick_valid;
  arb_side_t pick_side;

  assign d_req = d_read | d_write;

  arb_rr_pick u_rr_pick (
    .i_req      (i_read),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .grant      (pick_side),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= SIDE_D;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    l2_address   = '0;
    l2_wdata     = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = (pick_side == SIDE_I) ? SERVE_I : SERVE_D;
          last_grant_d = pick_side;
        end
      end

      SERVE_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        i_resp     = l2_resp;
        if (l2_resp) state_d = RELEASE;
        if (d_req && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end

      SERVE_D: begin
        // A write-back wins if the L1 ever raises both commands.
        l2_write   = d_write;
        l2_read    = d_read & ~d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
        if (l2_resp) state_d = RELEASE;
        if (i_read && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end

      // One dead cycle so a requester still holding its line after the
      // completion pulse is not granted a second time.
      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign i_rdata        = l2_rdata;
  assign d_rdata        = l2_rdata;
  assign contention_cnt = cnt_q;

endmodule
